// File: rtl/uart_pkg.sv
//==============================================================================
// Module   : uart_pkg
// Brief    : Shared types and frame helpers for the buffered UART transmitter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Total bit slots in one frame, start bit included.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
//==============================================================================
// Module   : uart_sync_fifo
// Brief    : Single-clock FIFO with registered pointers and occupancy count.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic [c_AW:0]    w_level;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign o_level = w_level;
    assign o_full  = (w_level == (c_AW + 1)'(DEPTH));
    assign o_empty = (w_level == '0);
    assign o_data  = r_mem[r_rd_ptr[c_AW-1:0]];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (c_AW + 1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (c_AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
//==============================================================================
// Module   : uart_tx_fifo
// Brief    : Buffered UART transmitter; FIFO-fed, back-to-back framing.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 10417,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_s,
    input  logic                          rst_s,
    input  logic                          iVALID,
    input  logic [DATA_BITS-1:0]          iDATA,
    output logic                          oREADY,
    output logic                          oDATA,
    output logic                          oFINISH,
    output logic                          oBUSY,
    output logic [$clog2(FIFO_DEPTH):0]   oLEVEL
);

    localparam int              c_CW          = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int              c_LW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CW-1:0] c_BAUD_LAST   = c_CW'(CLK_DIV - 1);
    localparam logic [c_CW-1:0] c_BAUD_PENULT = c_CW'(CLK_DIV - 2);
    localparam logic [3:0]      c_DATA_LAST   = 4'(DATA_BITS - 1);
    localparam logic [3:0]      c_STOP_LAST   = 4'(STOP_BITS - 1);
    localparam bit              c_HAS_PARITY  = (PARITY != int'(PAR_NONE));
    localparam bit              c_ODD_PARITY  = (PARITY == int'(PAR_ODD));

    if (CLK_DIV < 2) begin : g_chk_clk_div
        $error("uart_tx_fifo: CLK_DIV must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_e            r_state;
    tx_state_e            w_state_next;
    logic [c_CW-1:0]      r_baud;
    logic [3:0]           r_bitcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_finish;
    logic                 r_busy;

    logic                 w_tx_next;
    logic                 w_finish_next;
    logic                 w_pop;
    logic                 w_bit_clr;
    logic                 w_bit_inc;
    logic                 w_shift_en;
    logic                 w_bit_end;
    logic                 w_full;
    logic                 w_empty;
    logic [DATA_BITS-1:0] w_fifo_rd;
    logic [c_LW-1:0]      w_level;
    logic                 w_par_calc;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_s),
        .rst     (rst_s),
        .i_push  (iVALID),
        .i_data  (iDATA),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rd),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign oREADY  = !w_full;
    assign oLEVEL  = w_level;
    assign oDATA   = r_tx;
    assign oFINISH = r_finish;
    assign oBUSY   = r_busy;

    assign w_bit_end  = (r_baud == c_BAUD_LAST);
    assign w_par_calc = c_ODD_PARITY ? ~(^w_fifo_rd) : (^w_fifo_rd);

    always_ff @(posedge clk_s) begin
        if (rst_s) begin
            r_state  <= ST_IDLE;
            r_baud   <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_tx     <= 1'b1;
            r_finish <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Every state change lands on a bit boundary, so wrapping here also clears on entry.
            r_baud  <= (r_state == ST_IDLE || w_bit_end) ? '0 : r_baud + c_CW'(1);
            if (w_bit_clr) begin
                r_bitcnt <= '0;
            end else if (w_bit_inc) begin
                r_bitcnt <= r_bitcnt + 4'd1;
            end
            if (w_pop) begin
                r_shift <= w_fifo_rd;
                r_par   <= w_par_calc;
            end else if (w_shift_en) begin
                r_shift <= r_shift >> 1;
            end
            r_tx     <= w_tx_next;
            r_finish <= w_finish_next;
            r_busy   <= (w_state_next != ST_IDLE);
        end
    end

    // w_tx_next is the line level for the cycle after this edge.
    always_comb begin
        w_state_next  = r_state;
        w_tx_next     = r_tx;
        w_finish_next = 1'b0;
        w_pop         = 1'b0;
        w_bit_clr     = 1'b0;
        w_bit_inc     = 1'b0;
        w_shift_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx_next = 1'b1;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_bit_clr    = 1'b1;
                    w_state_next = ST_START;
                    w_tx_next    = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_next = ST_DATA;
                    w_tx_next    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bitcnt == c_DATA_LAST) begin
                        w_bit_clr = 1'b1;
                        if (c_HAS_PARITY) begin
                            w_state_next = ST_PARITY;
                            w_tx_next    = r_par;
                        end else begin
                            w_state_next = ST_STOP;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_bit_inc  = 1'b1;
                        w_shift_en = 1'b1;
                        w_tx_next  = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = ST_STOP;
                    w_tx_next    = 1'b1;
                end
            end
            ST_STOP: begin
                w_tx_next = 1'b1;
                if (r_bitcnt == c_STOP_LAST) begin
                    w_finish_next = (r_baud == c_BAUD_PENULT);
                    if (w_bit_end) begin
                        if (!w_empty) begin
                            w_pop        = 1'b1;
                            w_bit_clr    = 1'b1;
                            w_state_next = ST_START;
                            w_tx_next    = 1'b0;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end
                end else if (w_bit_end) begin
                    w_bit_inc = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
//==============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Directed self-checking bench for uart_tx_fifo in five frame formats.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [5];
    logic       valid [5];
    logic       tx    [5];
    logic       fin   [5];
    logic       busy  [5];
    logic       rdy   [5];
    logic [7:0] d0, d3;
    logic [6:0] d1, d2;
    logic [8:0] d4;
    logic [4:0] lv0, lv1, lv2, lv4;
    logic [2:0] lv3;

    int checks   = 0;
    int failures = 0;

    // 0: 8N1, 1: 7E2, 2: 7O2, 3: 8N1 depth 4, 4: 9N1 at divisor 2
    uart_tx_fifo #(.CLK_DIV(12), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8n1 (
        .clk_s(clk), .rst_s(rst[0]), .iVALID(valid[0]), .iDATA(d0), .oREADY(rdy[0]),
        .oDATA(tx[0]), .oFINISH(fin[0]), .oBUSY(busy[0]), .oLEVEL(lv0));
    uart_tx_fifo #(.CLK_DIV(12), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) u_7e2 (
        .clk_s(clk), .rst_s(rst[1]), .iVALID(valid[1]), .iDATA(d1), .oREADY(rdy[1]),
        .oDATA(tx[1]), .oFINISH(fin[1]), .oBUSY(busy[1]), .oLEVEL(lv1));
    uart_tx_fifo #(.CLK_DIV(12), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16)) u_7o2 (
        .clk_s(clk), .rst_s(rst[2]), .iVALID(valid[2]), .iDATA(d2), .oREADY(rdy[2]),
        .oDATA(tx[2]), .oFINISH(fin[2]), .oBUSY(busy[2]), .oLEVEL(lv2));
    uart_tx_fifo #(.CLK_DIV(12), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_d4 (
        .clk_s(clk), .rst_s(rst[3]), .iVALID(valid[3]), .iDATA(d3), .oREADY(rdy[3]),
        .oDATA(tx[3]), .oFINISH(fin[3]), .oBUSY(busy[3]), .oLEVEL(lv3));
    uart_tx_fifo #(.CLK_DIV(2), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_9n1 (
        .clk_s(clk), .rst_s(rst[4]), .iVALID(valid[4]), .iDATA(d4), .oREADY(rdy[4]),
        .oDATA(tx[4]), .oFINISH(fin[4]), .oBUSY(busy[4]), .oLEVEL(lv4));

    function automatic logic [4:0] lvl(input int u);
        case (u)
            0:       return lv0;
            1:       return lv1;
            2:       return lv2;
            3:       return {2'b00, lv3};
            default: return lv4;
        endcase
    endfunction

    task automatic set_data(input int u, input logic [8:0] d);
        case (u)
            0:       d0 = d[7:0];
            1:       d1 = d[6:0];
            2:       d2 = d[6:0];
            3:       d3 = d[7:0];
            default: d4 = d;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bit b of 'bits' is the b-th transmitted slot; each slot must hold for div cycles.
    task automatic capture(input int u, input int div, input int nbits, input logic [31:0] bits,
                           input bit pre, input int exp_nfin, input int f1e, input int f2e,
                           input string tag);
        int good [32];
        int nfin, f1, f2;
        for (int i = 0; i < 32; i++) good[i] = 0;
        nfin = 0; f1 = 0; f2 = 0;
        for (int c = 1; c <= nbits * div; c++) begin
            if (!(pre && c == 1)) begin
                tick();
                valid[u] = 1'b0;
            end
            if (tx[u] === bits[(c - 1) / div]) good[(c - 1) / div]++;
            if (fin[u] === 1'b1) begin
                nfin++;
                if (nfin == 1) f1 = c; else f2 = c;
            end
        end
        for (int b = 0; b < nbits; b++)
            check($sformatf("%s_bit%0d_cycles", tag, b), good[b], div);
        check($sformatf("%s_finish_count", tag), nfin, exp_nfin);
        check($sformatf("%s_finish1_cycle", tag), f1, f1e);
        if (exp_nfin > 1) check($sformatf("%s_finish2_cycle", tag), f2, f2e);
    endtask

    // Samples each data bit mid-slot; leaves the bench on the last cycle of the frame.
    task automatic rx_word(input int u, input int div, input int nd, input int nbits,
                           input bit pre, output logic [8:0] w);
        w = '0;
        for (int c = 1; c <= nbits * div; c++) begin
            if (!(pre && c == 1)) begin
                tick();
                valid[u] = 1'b0;
            end
            for (int i = 0; i < nd; i++)
                if (c == div * (1 + i) + div / 2) w[i] = tx[u];
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] w;
        logic       r;
        int         acc;
        int         k;
        int         bad;

        for (int i = 0; i < 5; i++) begin
            rst[i]   = 1'b1;
            valid[i] = 1'b0;
        end
        d0 = '0; d1 = '0; d2 = '0; d3 = '0; d4 = '0;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) rst[i] = 1'b0;
        tick();

        check("reset_oDATA",   tx[0],   1);
        check("reset_oREADY",  rdy[0],  1);
        check("reset_oFINISH", fin[0],  0);
        check("reset_oBUSY",   busy[0], 0);
        check("reset_oLEVEL",  lvl(0),  0);
        check("reset_oLEVEL_d4", lvl(3), 0);

        // 8N1 0xA5: slots 0,1,0,1,0,0,1,0,1,1
        set_data(0, 9'h0A5); valid[0] = 1'b1; tick(); valid[0] = 1'b0;
        check("8n1_level_after_write", lvl(0), 1);
        check("8n1_busy_after_write",  busy[0], 0);
        check("8n1_line_after_write",  tx[0], 1);
        tick();
        check("8n1_busy_after_pop", busy[0], 1);
        check("8n1_start_bit",      tx[0], 0);
        capture(0, 12, 10, 32'h34A, 1'b1, 1, 120, 0, "8n1");
        tick();
        check("8n1_busy_end",  busy[0], 0);
        check("8n1_line_end",  tx[0], 1);
        check("8n1_level_end", lvl(0), 0);

        // 7E2 0x07: three ones -> even parity bit 1
        set_data(1, 9'h007); valid[1] = 1'b1; tick(); valid[1] = 1'b0; tick();
        capture(1, 12, 11, 32'h70E, 1'b1, 1, 132, 0, "7e2");
        tick();
        check("7e2_busy_end", busy[1], 0);

        // 7O2 0x07: odd parity bit 0
        set_data(2, 9'h007); valid[2] = 1'b1; tick(); valid[2] = 1'b0; tick();
        capture(2, 12, 11, 32'h60E, 1'b1, 1, 132, 0, "7o2");
        tick();
        check("7o2_busy_end", busy[2], 0);

        // Back-to-back 0x55 then 0x0F: second push coincides with first pop
        set_data(0, 9'h055); valid[0] = 1'b1; tick();
        set_data(0, 9'h00F); tick(); valid[0] = 1'b0;
        check("b2b_level_push_pop", lvl(0), 1);
        check("b2b_start_bit", tx[0], 0);
        capture(0, 12, 20, 32'h87AAA, 1'b1, 2, 120, 240, "b2b");
        tick();
        check("b2b_busy_end", busy[0], 0);

        // Depth-4 FIFO flooded from idle with 0,1,2,...
        set_data(3, 9'h000); valid[3] = 1'b1; acc = 0;
        for (int i = 0; i < 8; i++) begin
            r = rdy[3];
            tick();
            if (r) begin
                acc++;
                set_data(3, 9'(acc));
            end
        end
        check("full_accepted", acc, 5);
        check("full_ready_low", rdy[3], 0);
        check("full_level", lvl(3), 4);
        // first write landed 7 edges before this point; its finish is frame cycle 120
        k = 0;
        while (fin[3] !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
        check("full_finish_wait", k, 113);
        tick();
        check("full_ready_after_pop", rdy[3], 1);
        check("full_level_after_pop", lvl(3), 3);
        rx_word(3, 12, 8, 10, 1'b1, w);
        check("full_word1", w, 1);
        check("full_level_refilled", lvl(3), 4);
        for (int n = 2; n <= 5; n++) begin
            rx_word(3, 12, 8, 10, 1'b0, w);
            check($sformatf("full_word%0d", n), w, n);
        end
        tick();
        check("full_busy_end", busy[3], 0);
        check("full_level_end", lvl(3), 0);

        // Reset in frame cycle 50 with 3 words queued
        set_data(0, 9'h011); valid[0] = 1'b1; tick();
        set_data(0, 9'h022); tick();
        set_data(0, 9'h033); tick(); valid[0] = 1'b0;
        check("rstmid_level_queued", lvl(0), 2);
        bad = 0;
        repeat (47) begin
            tick();
            if (fin[0] === 1'b1) bad++;
        end
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        check("rstmid_line",   tx[0],   1);
        check("rstmid_level",  lvl(0),  0);
        check("rstmid_busy",   busy[0], 0);
        check("rstmid_finish", fin[0],  0);
        check("rstmid_ready",  rdy[0],  1);
        check("rstmid_no_finish_before", bad, 0);
        bad = 0;
        repeat (150) begin
            tick();
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || fin[0] !== 1'b0 || lvl(0) !== 5'd0) bad++;
        end
        check("rstmid_quiet_cycles_bad", bad, 0);

        // Minimum divisor, 9 data bits all ones
        set_data(4, 9'h1FF); valid[4] = 1'b1; tick(); valid[4] = 1'b0; tick();
        check("div2_start_bit", tx[4], 0);
        capture(4, 2, 11, 32'h7FE, 1'b1, 1, 22, 0, "div2");
        tick();
        check("div2_busy_end", busy[4], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter. Bytes are written through a valid/ready handshake into an internal FIFO and serialised back-to-back on a single TX line. Frame format is fixed at elaboration: data width, parity mode and stop-bit count. It sits between a host-side command/trace producer and the board UART pin, and replaces the unbuffered single-byte, fixed-8N1 transmitter for multi-byte reporting.

## Interface
- CLK_DIV, 10417: clock cycles per bit; 10417 gives 9600 bps at 100 MHz; legal range ≥ 2.
- DATA_BITS, 8: data bits per frame, 5–9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: entries; power of two, ≥ 2.
- clk_s  in  1  system clock.
- rst_s  in  1  reset; synchronous, active-high.
- iVALID  in  1  write request.
- iDATA  in  DATA_BITS  write data, LSB transmitted first.
- oREADY  out  1  FIFO not full; a write occurs on an edge where iVALID && oREADY.
- oDATA  out  1  serial line, idle high.
- oFINISH  out  1  one-cycle pulse per completed frame.
- oBUSY  out  1  frame in progress.
- oLEVEL  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START when FIFO is non-empty. The word is popped into the shift register and the bit counter is cleared.
- START → DATA after CLK_DIV cycles.
- DATA → PARITY (PARITY ≠ 0) or STOP after DATA_BITS bits.
- PARITY → STOP after one bit.
- STOP lasts STOP_BITS bit times.
- At the end of STOP:
  - FIFO non-empty → pop and go directly to START, with no idle gap.
  - FIFO empty → IDLE.
- Parity bit:
  - even = XOR of data bits.
  - odd = inverted XOR.
  - Computed from the popped word.
- Frame bits: 1 + DATA_BITS + (PARITY≠0) + STOP_BITS. Frame cycles = CLK_DIV × frame bits.
- Baud counter runs 0..CLK_DIV-1, is cleared on every state entry, and advances only while not IDLE.
- FIFO behaviour:
  - Write when iVALID && oREADY.
  - oREADY = !full.
  - A write while full is impossible by handshake; iVALID with oREADY low is ignored and causes no state change.
  - Simultaneous write and pop: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- oBUSY = state ≠ IDLE.
- Reset mid-frame: at the reset edge, the frame is abandoned with no oFINISH, the FIFO is flushed and the line returns high.

## Timing
- Reset values: oDATA = 1, oREADY = 1, oFINISH = 0, oBUSY = 0, oLEVEL = 0.
- All outputs are registered except oREADY and oLEVEL, which are derived from registered pointers.
- Latency, for a write accepted at edge E while IDLE:
  - oLEVEL = 1 after E.
  - The pop occurs at E+1, so oDATA falls and oBUSY rises after E+1.
- Each bit holds oDATA for exactly CLK_DIV cycles.
- oFINISH is high for exactly one cycle: the last cycle of the final stop bit.
- When back-to-back frames run, the next start bit begins on the cycle after the oFINISH cycle.

## Structure
- Shared package uart_pkg contains:
  - parity enum (PAR_NONE/PAR_ODD/PAR_EVEN).
  - FSM state enum.
  - function frame_bits(DATA_BITS, PARITY, STOP_BITS).
- Elaboration-time checks on the parameter ranges belong in the top module.
- One sub-module: uart_sync_fifo, a single-clock FIFO parametrised on WIDTH and DEPTH with push/pop/full/empty/level.
- FSM, baud counter and shift register live in uart_tx_fifo.

## Test plan
All scenarios use CLK_DIV = 12 unless noted.
- **8N1, single byte:** write 0xA5 while idle -> oDATA sequence 0,1,0,1,0,0,1,0,1,1, each bit 12 cycles; oFINISH pulses on frame cycle 120; oBUSY falls on the next cycle.
- **Parity:**
  - DATA_BITS = 7, PARITY = 2, STOP_BITS = 2, byte 0x07 -> parity bit 1, frame 132 cycles.
  - Same with PARITY = 1 -> parity bit 0.
- **Back-to-back:** write 0x55 then 0x0F on consecutive edges -> contiguous 240-cycle transmission with no high gap between frames; oFINISH pulses exactly 120 cycles apart.
- **FIFO full:** FIFO_DEPTH = 4, iVALID held high from idle with an incrementing pattern -> exactly 5 words accepted; oREADY low with oLEVEL = 4; after the first oFINISH, oREADY rises and one more word is accepted; transmit order matches write order.
- **Reset mid-frame:** assert rst_s on cycle 50 of a frame with 3 words queued -> oDATA = 1, oLEVEL = 0, oBUSY = 0 after that edge; no oFINISH; no further traffic.
- **Minimum divisor:** CLK_DIV = 2, 9 data bits, word 0x1FF -> 22-cycle frame, all bits 2 cycles wide.
